// File: rtl/mem_access_ctrl.sv
// Load/store unit for a word-addressed memory (asynchronous read, negedge write).
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
module mem_access_ctrl #(
    parameter int unsigned AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    output logic          dm_we,
    input  logic [31:0]   dm_dout
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    localparam logic [1:0] SzByte = 2'b00;
    localparam logic [1:0] SzHalf = 2'b01;

    state_e        state_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rbuf_q;
    logic [31:0]   rdata_q;
    logic [1:0]    size_q;
    logic          we_q;
    logic          sign_q;
    logic          done_q;
    logic          err_q;

    logic          misaligned;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_value;

    // Upper address bits fall outside the memory and are dropped (address wrap).
    logic unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    always_comb begin
        unique case (size)
            SzByte:  misaligned = 1'b0;
            SzHalf:  misaligned = addr[0];
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = addr_q[1] ? dm_dout[31:16] : dm_dout[15:0];
        ld_value = dm_dout;
        unique case (addr_q[1:0])
            2'd0: ld_byte = dm_dout[7:0];
            2'd1: ld_byte = dm_dout[15:8];
            2'd2: ld_byte = dm_dout[23:16];
            2'd3: ld_byte = dm_dout[31:24];
            default: ld_byte = 8'h00;
        endcase
        unique case (size_q)
            SzByte:  ld_value = {{24{sign_q & ld_byte[7]}}, ld_byte};
            SzHalf:  ld_value = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ld_value = dm_dout;
        endcase
    end

    // Merge store data into the word captured during READ.
    always_comb begin
        dm_din = rbuf_q;
        unique case (size_q)
            SzByte: begin
                unique case (addr_q[1:0])
                    2'd0: dm_din[7:0]   = wdata_q[7:0];
                    2'd1: dm_din[15:8]  = wdata_q[7:0];
                    2'd2: dm_din[23:16] = wdata_q[7:0];
                    2'd3: dm_din[31:24] = wdata_q[7:0];
                    default: dm_din = rbuf_q;
                endcase
            end
            SzHalf: begin
                if (addr_q[1]) begin
                    dm_din[31:16] = wdata_q[15:0];
                end else begin
                    dm_din[15:0] = wdata_q[15:0];
                end
            end
            default: dm_din = wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q  <= addr[AW+1:0];
                        wdata_q <= wdata;
                        size_q  <= size;
                        we_q    <= we;
                        sign_q  <= sign_ext;
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else if (we && size[1]) begin
                            state_q <= StWrite;
                        end else begin
                            state_q <= StRead;
                        end
                    end
                end
                StRead: begin
                    rbuf_q <= dm_dout;
                    if (we_q) begin
                        state_q <= StWrite;
                    end else begin
                        rdata_q <= ld_value;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StWrite: begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready   = (state_q == StIdle);
    assign dm_we   = (state_q == StWrite);
    assign dm_addr = addr_q[AW+1:2];
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-lane arithmetic reference model,
// plus directed cases for busy-time requests and reset during READ/WRITE.
module tb_mem_access_ctrl;

    localparam int unsigned AW    = 10;
    localparam int unsigned Words = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          sign_ext = 1'b0;
    logic [31:0]   addr = 32'h0;
    logic [31:0]   wdata = 32'h0;
    logic          ready;
    logic          done;
    logic          err;
    logic [31:0]   rdata;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;
    logic          dm_we;
    logic [31:0]   dm_dout;

    logic [31:0]   mem     [Words];
    logic [31:0]   ref_mem [Words];
    logic [31:0]   ref_rdata = 32'h0;
    logic [31:0]   last_din = 32'h0;
    logic [AW-1:0] last_waddr = '0;
    int            we_cnt = 0;
    int            n_vec = 0;
    int            n_fail = 0;

    mem_access_ctrl #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_we    (dm_we),
        .dm_dout  (dm_dout)
    );

    always #5 clk = ~clk;

    assign dm_dout = mem[dm_addr];

    always @(negedge clk) begin
        if (dm_we) begin
            mem[dm_addr] = dm_din;
            last_din     = dm_din;
            last_waddr   = dm_addr;
            we_cnt       = we_cnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic int lane_bits(input logic [1:0] sz);
        return (sz == 2'd0) ? 8 : 16;
    endfunction

    function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd0) ? int'(a[1:0]) : 2 * int'(a[1]);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic sx, input logic [31:0] a);
        longint v;
        int     bits;
        if (sz[1]) return word;
        bits = lane_bits(sz);
        v = (longint'(word) >> (8 * lane_off(sz, a))) % (longint'(1) << bits);
        if (sx && v >= (longint'(1) << (bits - 1))) v -= longint'(1) << bits;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [31:0] a, input logic [31:0] wd);
        longint mask;
        longint lane;
        longint v;
        int     bits;
        if (sz[1]) return wd;
        bits = lane_bits(sz);
        mask = ((longint'(1) << bits) - 1) << (8 * lane_off(sz, a));
        lane = (longint'(wd) % (longint'(1) << bits)) << (8 * lane_off(sz, a));
        v = (longint'(word) & ~mask) | lane;
        return v[31:0];
    endfunction

    task automatic wait_ready(input string tag);
        int guard = 0;
        while (!ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " ready"}, 32'(ready), 32'd1);
    endtask

    task automatic run_access(input string tag, input logic w, input logic [1:0] sz,
                              input logic sx, input logic [31:0] a, input logic [31:0] wd);
        int            lat;
        int            we0;
        int            exp_lat;
        logic          mis;
        logic [AW-1:0] idx;
        idx = a[AW+1:2];
        mis = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        wait_ready(tag);
        we0 = we_cnt;
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign_ext = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        lat = 1;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (mis) exp_lat = 1;
        else if (!w || sz[1]) exp_lat = 2;
        else exp_lat = 3;
        if (!mis) begin
            if (w) ref_mem[idx] = model_store(ref_mem[idx], sz, a, wd);
            else ref_rdata = model_load(ref_mem[idx], sz, sx, a);
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(err), 32'(mis));
        check({tag, " rdata"}, rdata, ref_rdata);
        check({tag, " writes"}, 32'(we_cnt - we0), (w && !mis) ? 32'd1 : 32'd0);
        check({tag, " mem"}, mem[idx], ref_mem[idx]);
        @(posedge clk); #1;
        check({tag, " done pulse"}, {31'd0, done, err}, 32'd0);
    endtask

    initial begin
        int we0;
        logic [31:0] a;
        logic [1:0]  sz;

        for (int i = 0; i < Words; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4]     = 32'hA1B2C3D4;
        ref_mem[4] = 32'hA1B2C3D4;

        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("reset ready", 32'(ready), 32'd1);
        check("reset done_err", {30'd0, done, err}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset dm_addr", 32'(dm_addr), 32'd0);
        check("reset dm_we", 32'(dm_we), 32'd0);

        run_access("lb sx 0x13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lb sx value", rdata, 32'hFFFFFFA1);
        run_access("lbu 0x13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check("lbu value", rdata, 32'h000000A1);
        run_access("lh sx 0x12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        check("lh sx value", rdata, 32'hFFFFA1B2);
        run_access("lw 0x10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw value", rdata, 32'hA1B2C3D4);

        run_access("sb 0x11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055);
        check("sb dm_din", last_din, 32'hA1B255D4);
        run_access("lw after sb", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lw after sb value", rdata, 32'hA1B255D4);

        run_access("sh misaligned", 1'b1, 2'd1, 1'b0, 32'h11, 32'h0000BEEF);
        run_access("lw misaligned", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
        check("misaligned keeps rdata", rdata, 32'hA1B255D4);

        // Word store with req held high and a conflicting request while busy.
        wait_ready("busy");
        we0 = we_cnt;
        req = 1'b1; we = 1'b1; size = 2'd2; sign_ext = 1'b0;
        addr = 32'h20; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("busy ready low", 32'(ready), 32'd0);
        addr = 32'h24; wdata = 32'h12345678;
        @(posedge clk); #1;
        check("busy first done", 32'(done), 32'd1);
        check("busy word 8", mem[8], 32'hDEADBEEF);
        check("busy one write", 32'(we_cnt - we0), 32'd1);
        check("busy write addr", 32'(last_waddr), 32'd8);
        @(posedge clk); #1;
        check("busy ready again", 32'(ready), 32'd1);
        check("busy still one write", 32'(we_cnt - we0), 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("busy second done", 32'(done), 32'd1);
        check("busy word 9", mem[9], 32'h12345678);
        check("busy two writes", 32'(we_cnt - we0), 32'd2);
        ref_mem[8] = 32'hDEADBEEF;
        ref_mem[9] = 32'h12345678;
        @(posedge clk); #1;

        // Reset during READ of a byte store: no write, rdata cleared.
        wait_ready("rst read");
        we0 = we_cnt;
        req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h12; wdata = 32'h99;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst read no write", 32'(we_cnt - we0), 32'd0);
        check("rst read mem", mem[4], ref_mem[4]);
        check("rst read rdata", rdata, 32'd0);
        check("rst read ready", 32'(ready), 32'd1);
        ref_rdata = 32'h0;

        // Reset during WRITE of a byte store: write lands, no done pulse.
        run_access("lw before rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        wait_ready("rst write");
        we0 = we_cnt;
        req = 1'b1; we = 1'b1; size = 2'd0; addr = 32'h11; wdata = 32'h00000077;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rst write in WRITE", 32'(dm_we), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[4] = model_store(ref_mem[4], 2'd0, 32'h11, 32'h77);
        ref_rdata  = 32'h0;
        check("rst write landed", mem[4], ref_mem[4]);
        check("rst write count", 32'(we_cnt - we0), 32'd1);
        check("rst write no done", 32'(done), 32'd0);
        check("rst write ready", 32'(ready), 32'd1);
        check("rst write rdata", rdata, 32'd0);
        check("rst write dm_we", 32'(dm_we), 32'd0);
        @(posedge clk); #1;
        check("rst write no late done", {31'd0, done | dm_we}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[11:2] = 10'($urandom_range(0, 7));
            sz = 2'($urandom);
            run_access("random", 1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Initiator-side load/store unit that drives the word-addressed data memory, which is 1024 x 32, has an asynchronous read, and writes on the clock's negative edge. The CPU side sees byte, halfword and word accesses. Sub-word loads are done by lane extraction plus sign or zero extension. Sub-word stores are done by a read-modify-write, because the memory only supports whole-word writes. A small FSM sequences each access and reports completion with a one-cycle done pulse.

Parameters:
AW, 10, memory word-address width; the memory address uses byte-address bits [AW+1:2].

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  1  access request; sampled only while ready=1.
we  input  1  1 = store, 0 = load; sampled with req.
size  input  2  access size: 00 byte, 01 halfword, 10 word (11 is treated as word).
sign_ext  input  1  for loads: 1 sign-extends, 0 zero-extends; sampled with req.
addr  input  32  byte address; bits [31:AW+2] are ignored.
wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
ready  output  1  high only in IDLE.
done  output  1  one-cycle completion pulse.
err  output  1  misalignment flag; valid when done=1, 0 otherwise.
rdata  output  32  load result; updated only on a successful load, held until the next one.
dm_addr  output  AW  word address to memory, equal to latched addr[AW+1:2].
dm_din  output  32  merged write word to memory.
dm_we  output  1  memory write enable; high only in WRITE.
dm_dout  input  32  asynchronous read data from memory.

Behaviour:
- Reset (synchronous, at the rising edge with rst=1) sets:
  - state = IDLE, done = 0, err = 0, rdata = 0;
  - the latched address, data, size, we and sign registers = 0, so dm_addr = 0;
  - read buffer = 0;
  - dm_we = 0 from the next cycle on.
- States: IDLE, READ, WRITE, DONE, encoded in 2 bits. dm_we = (state==WRITE), decoded combinationally.
- IDLE:
  - ready = 1.
  - On req=1, latch addr, wdata, size, we and sign_ext.
  - Misaligned means halfword with addr[0]=1, or word with addr[1:0]!=0. Then set err_next = 1 and go to DONE. There is no memory access.
  - Otherwise: a load goes to READ; a sub-word store goes to READ; a word store goes to WRITE.
- READ:
  - dm_addr shows the latched address; capture dm_dout into the read buffer at the rising edge.
  - A load also writes the extracted and extended value into rdata at that edge, then goes to DONE.
  - A store goes to WRITE.
- WRITE:
  - dm_we = 1.
  - dm_din = merged word:
    - byte store: read buffer with lane addr[1:0] replaced by wdata[7:0];
    - halfword store: lane addr[1] replaced by wdata[15:0];
    - word store: wdata.
  - The memory captures the word on the falling edge inside this cycle. Next state is DONE.
- DONE: done = 1 for one cycle, err as set at request time. Returns to IDLE; the next req is accepted the following cycle.
- Byte order is little-endian: byte lane n = bits [8n+7:8n].
- Load extraction: byte uses lane addr[1:0]; halfword uses lane addr[1]; bit 7 or bit 15 is replicated when sign_ext=1, zeros are filled otherwise.
- Latency from the req-accepting edge to done high:
  - load: 2 cycles;
  - sub-word store: 3 cycles;
  - word store: 2 cycles;
  - misaligned access: 1 cycle.
- req while ready=0 is ignored (not queued). CPU inputs may change after acceptance without effect.
- rst asserted during WRITE: the falling-edge write of that cycle still completes. The FSM returns to IDLE at the next rising edge, and no done pulse is issued.
- rst asserted in READ: no write occurs, and rdata is cleared.
- Addresses wrap modulo 2^(AW+2) bytes.

Test Plan:
1. Memory word 4 (byte address 0x10) preset to 0xA1B2C3D4; load byte, sign_ext=1, addr 0x13 -> done 2 cycles after acceptance, rdata=0xFFFFFFA1, err=0, dm_we never high.
2. Same word, load byte, sign_ext=0, addr 0x13 -> rdata=0x000000A1. Load halfword, sign_ext=1, addr 0x12 -> rdata=0xFFFFA1B2. Load word, addr 0x10 -> rdata=0xA1B2C3D4.
3. Store byte wdata=0x00000055 at addr 0x11 -> READ, WRITE, DONE, with dm_we high exactly one cycle and dm_din=0xA1B255D4. A subsequent word load at 0x10 returns 0xA1B255D4.
4. Store halfword at addr 0x11, and separately load word at addr 0x12 -> done with err=1 one cycle after acceptance, no dm_we, memory and rdata unchanged.
5. Word store 0xDEADBEEF at 0x20, with req held high and a second conflicting req (addr 0x24) during the busy cycle -> one write only, to word 8 with 0xDEADBEEF. The second request is accepted only once ready=1 again.
6. rst pulsed while in WRITE of a byte store -> that write lands in memory, no done pulse, ready=1 and rdata=0 after the next rising edge, and dm_we=0 thereafter.
